// File: rtl/counter_updown_mod_pkg.sv
// ---------------------------------------------------------------------------
// counter_updown_mod_pkg
//   Shared definitions for the modulo-N counter family.
//   - action_e       : the one action a counter takes on a clock edge, in
//                      priority order (clear beats load beats count beats hold)
//   - select_action  : collapses the sync_clr / load / en controls into an
//                      action_e so every counter resolves priority the same way
//   - mod_max        : largest count value for a given modulus (MODULUS-1)
// ---------------------------------------------------------------------------
package counter_updown_mod_pkg;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_COUNT = 2'd1,
        ACT_LOAD  = 2'd2,
        ACT_CLEAR = 2'd3
    } action_e;

    // Synchronous clear wins over load, and load wins over counting, so an
    // enabled counter that is also being loaded takes the loaded value only.
    function automatic action_e select_action(input logic sync_clr,
                                              input logic load,
                                              input logic en);
        action_e act;
        if (sync_clr) begin
            act = ACT_CLEAR;
        end else if (load) begin
            act = ACT_LOAD;
        end else if (en) begin
            act = ACT_COUNT;
        end else begin
            act = ACT_HOLD;
        end
        return act;
    endfunction

    function automatic int mod_max(input int modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/counter_updown_mod_next_count.sv
// ---------------------------------------------------------------------------
// mod_next_count
//   Purely combinational next-value logic for a modulo-MODULUS up/down
//   counter. Given the current count and the direction it returns the value
//   the counter would take if it counted, and whether that step wraps.
// Ports
//   q       in   WIDTH  current count (always 0..MODULUS-1)
//   up      in   1      1 = increment, 0 = decrement
//   next_q  out  WIDTH  count after one step in the selected direction
//   wrap    out  1      step crosses the MODULUS-1 <-> 0 boundary
// ---------------------------------------------------------------------------
module mod_next_count
    import counter_updown_mod_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    output logic [WIDTH-1:0] next_q,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    generate
        if (MODULUS == (1 << WIDTH)) begin : g_pow2
            // A full binary range wraps by natural unsigned overflow, so the
            // wrap flag is just the all-ones / all-zeros detect.
            always_comb begin
                next_q = up ? (q + ONE) : (q - ONE);
                wrap   = up ? (&q) : (q == '0);
            end
        end else begin : g_mod
            localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(mod_max(MODULUS));

            // Partial range needs explicit compares against the endpoints
            // to fold the count back into 0..MODULUS-1.
            always_comb begin
                wrap   = 1'b0;
                next_q = q;
                if (up) begin
                    wrap   = (q == MAX_COUNT);
                    next_q = wrap ? '0 : (q + ONE);
                end else begin
                    wrap   = (q == '0);
                    next_q = wrap ? MAX_COUNT : (q - ONE);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/counter_updown_mod.sv
// ---------------------------------------------------------------------------
// counter_updown_mod
//   Synchronous modulo-MODULUS up/down counter with saturating parallel load,
//   count enable, combinational terminal count and a registered wrap pulse.
//   All bits update on the same clk edge; tc lets several of these cascade.
// Ports
//   clk       in   1      clock, state updates on posedge
//   clear     in   1      asynchronous active-high reset (q=0, ovf=0)
//   sync_clr  in   1      synchronous clear
//   load      in   1      synchronous load of d (saturates at MODULUS-1)
//   en        in   1      count enable
//   up        in   1      direction: 1 = increment, 0 = decrement
//   d         in   WIDTH  load value
//   q         out  WIDTH  registered count
//   tc        out  1      en & (up ? q==MODULUS-1 : q==0)
//   ovf       out  1      one-cycle pulse after an edge that wrapped
// ---------------------------------------------------------------------------
module counter_updown_mod
    import counter_updown_mod_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sync_clr,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(mod_max(MODULUS));

    logic [WIDTH-1:0] count_next;
    logic             count_wrap;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] q_next;
    logic             ovf_next;
    action_e          action;

    mod_next_count #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q      (q),
        .up     (up),
        .next_q (count_next),
        .wrap   (count_wrap)
    );

    // Loads above the top of the range clamp to MODULUS-1 so q can never
    // leave 0..MODULUS-1. With a full binary range every d is already legal.
    generate
        if (MODULUS == (1 << WIDTH)) begin : g_load_full
            assign load_value = d;
        end else begin : g_load_sat
            assign load_value = (d > MAX_COUNT) ? MAX_COUNT : d;
        end
    endgenerate

    // Priority mux: pick the single action for this edge, then the value q
    // and ovf take. ovf only rises on a counting step that wrapped.
    always_comb begin
        action   = select_action(sync_clr, load, en);
        q_next   = q;
        ovf_next = 1'b0;
        case (action)
            ACT_CLEAR: q_next = '0;
            ACT_LOAD:  q_next = load_value;
            ACT_COUNT: begin
                q_next   = count_next;
                ovf_next = count_wrap;
            end
            default:   q_next = q;
        endcase
    end

    // Count and wrap-pulse registers; clear takes effect without a clock.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q   <= '0;
            ovf <= 1'b0;
        end else begin
            q   <= q_next;
            ovf <= ovf_next;
        end
    end

    // Terminal count looks at the current q only, so a cascaded stage sees
    // it in the same cycle the lower stage is about to wrap.
    assign tc = en & (up ? (q == MAX_COUNT) : (q == '0));

endmodule

// File: tb/tb_counter_updown_mod.sv
// ---------------------------------------------------------------------------
// tb_counter_updown_mod
//   Drives a MODULUS=10 and a MODULUS=16 counter from the same inputs and
//   compares both against an arithmetic modulo model.
// ---------------------------------------------------------------------------
module tb_counter_updown_mod;

    logic       clk = 1'b0;
    logic       clear;
    logic       sync_clr;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] d;
    logic [3:0] q10;
    logic       tc10;
    logic       ovf10;
    logic [3:0] q16;
    logic       tc16;
    logic       ovf16;

    int num_checks = 0;
    int num_fails  = 0;

    int model_q10   = 0;
    int model_ovf10 = 0;
    int model_q16   = 0;
    int model_ovf16 = 0;

    counter_updown_mod #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk      (clk),
        .clear    (clear),
        .sync_clr (sync_clr),
        .load     (load),
        .en       (en),
        .up       (up),
        .d        (d),
        .q        (q10),
        .tc       (tc10),
        .ovf      (ovf10)
    );

    counter_updown_mod #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk      (clk),
        .clear    (clear),
        .sync_clr (sync_clr),
        .load     (load),
        .en       (en),
        .up       (up),
        .d        (d),
        .q        (q16),
        .tc       (tc16),
        .ovf      (ovf16)
    );

    // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // One edge of a modulo-m counter, straight from its rules.
    task automatic model_step(input int m, input bit sc, input bit ld, input bit e,
                              input bit u, input int dv, inout int mq, inout int mo);
        if (sc) begin
            mq = 0;
            mo = 0;
        end else if (ld) begin
            mq = (dv >= m) ? m - 1 : dv;
            mo = 0;
        end else if (e) begin
            if (u) begin
                mo = (mq == m - 1) ? 1 : 0;
                mq = (mq + 1) % m;
            end else begin
                mo = (mq == 0) ? 1 : 0;
                mq = (mq + m - 1) % m;
            end
        end else begin
            mo = 0;
        end
    endtask

    function automatic bit model_tc(input int m, input int mq, input bit e, input bit u);
        return e && (u ? (mq == m - 1) : (mq == 0));
    endfunction

    // Drive one cycle's controls, check tc before the edge, then check q/ovf
    // just after it. Called between edges.
    task automatic apply_stimulus(input bit sc, input bit ld, input bit e,
                                  input bit u, input int dv);
        sync_clr = sc;
        load     = ld;
        en       = e;
        up       = u;
        d        = 4'(dv);
        #1;
        check_output("tc10", 32'(tc10), 32'(model_tc(10, model_q10, e, u)));
        check_output("tc16", 32'(tc16), 32'(model_tc(16, model_q16, e, u)));
        @(posedge clk);
        model_step(10, sc, ld, e, u, dv, model_q10, model_ovf10);
        model_step(16, sc, ld, e, u, dv, model_q16, model_ovf16);
        #1;
        check_output("q10", 32'(q10), 32'(model_q10));
        check_output("ovf10", 32'(ovf10), 32'(model_ovf10));
        check_output("q16", 32'(q16), 32'(model_q16));
        check_output("ovf16", 32'(ovf16), 32'(model_ovf16));
    endtask

    // Asynchronous clear between edges: outputs must drop without a clock.
    task automatic pulse_clear();
        clear = 1'b1;
        #1;
        model_q10 = 0; model_ovf10 = 0;
        model_q16 = 0; model_ovf16 = 0;
        check_output("async_clr_q10", 32'(q10), 32'(model_q10));
        check_output("async_clr_ovf10", 32'(ovf10), 32'(model_ovf10));
        check_output("async_clr_q16", 32'(q16), 32'(model_q16));
        check_output("async_clr_ovf16", 32'(ovf16), 32'(model_ovf16));
        clear = 1'b0;
        #1;
    endtask

    initial begin
        clear    = 1'b1;
        sync_clr = 1'b0;
        load     = 1'b0;
        en       = 1'b0;
        up       = 1'b1;
        d        = '0;
        #1;
        check_output("reset_q10", 32'(q10), 32'd0);
        check_output("reset_ovf10", 32'(ovf10), 32'd0);
        check_output("reset_tc10", 32'(tc10), 32'd0);
        check_output("reset_q16", 32'(q16), 32'd0);

        // Counter must hold at zero through edges while clear stays high.
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_output("hold_in_clear_q10", 32'(q10), 32'd0);
            check_output("hold_in_clear_q16", 32'(q16), 32'd0);
        end
        clear = 1'b0;
        en    = 1'b0;
        #1;

        // Idle edges with en low.
        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 1, 0);

        // Count up through the wrap: 1..9, 0, 1.
        for (int i = 0; i < 11; i++) apply_stimulus(0, 0, 1, 1, 0);

        // From zero, count down: wraps to 9 with ovf, then 8.
        apply_stimulus(1, 0, 0, 1, 0);
        apply_stimulus(0, 0, 1, 0, 0);
        apply_stimulus(0, 0, 1, 0, 0);

        // Load beats en, loads saturate, sync_clr beats load.
        apply_stimulus(0, 1, 1, 1, 7);
        apply_stimulus(0, 1, 0, 1, 12);
        apply_stimulus(1, 1, 0, 1, 5);

        // Asynchronous clear while counting at q=5, then resume.
        apply_stimulus(0, 1, 0, 1, 5);
        en = 1'b1;
        pulse_clear();
        apply_stimulus(0, 0, 1, 1, 0);

        // Full-range wrap on the 16 counter, then direction toggling.
        apply_stimulus(0, 1, 0, 1, 15);
        apply_stimulus(0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 1, (i % 2) == 0, 0);

        // Randomised mix of all controls with occasional async clears.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) pulse_clear();
            apply_stimulus($urandom_range(0, 15) == 0,
                           $urandom_range(0, 7) == 0,
                           $urandom_range(0, 3) != 0,
                           1'($urandom_range(0, 1)),
                           int'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 num_checks, num_fails);
        $finish;
    end

endmodule
